// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- pipeline-stage register for inter-stage boundaries.
//
// Holds a DATA_W-bit payload bundle behind a valid/ready handshake, with a
// synchronous flush and a known bubble value (NOP_VALUE) shown whenever the
// stage is empty.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1. A source holds valid and data stable until the transfer. A sink may
// change ready at any time. This stage keeps out_data stable while
// out_valid=1 and out_ready=0.
//
// SKID=0 : one entry. in_ready = !out_valid | out_ready (combinational path
//          from out_ready to in_ready).
// SKID=1 : two entries (head + skid). in_ready depends only on the state flops
//          and rst_n, which breaks the ready chain between stages.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   flush      in   drop all held entries and any same-cycle input transfer
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept (forced 0 while rst_n=0)
//   in_data    in   upstream payload
//   out_valid  out  head entry valid
//   out_ready  in   downstream accepts
//   out_data   out  head payload, or NOP_VALUE when out_valid=0
//   occupancy  out  held entries (0..2). This is also the FSM state encoding.
module pipe_stage_buf #(
  parameter int          DATA_W    = 32,
  parameter int          SKID      = 1,
  parameter logic [31:0] NOP_VALUE = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // The NOP is zero-extended or truncated to the payload width.
  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_VALUE);

  // The state encoding is the entry count, so occupancy shows the state directly.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= NOP_W;
      skid_q  <= NOP_W;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and data-path logic.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      // A same-cycle input transfer still completes upstream but is dropped here.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            head_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head_d = in_data;
          end else if (in_fire) begin
            if (SKID != 0) begin
              state_d = ST_TWO;
              skid_d  = in_data;
            end else begin
              // Unreachable with SKID=0: in_ready is low when the head is stalled.
              head_d = in_data;
            end
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // No input is accepted here, so the skid entry can never be overwritten.
          if (out_fire) begin
            state_d = ST_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_data  = out_valid ? head_q : NOP_W;
    occupancy = state_q;
    if (SKID != 0) begin
      in_ready = rst_n & (state_q != ST_TWO);
    end else begin
      in_ready = rst_n & (!out_valid | out_ready);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf. One SKID=1 instance and one SKID=0 instance share
// the same inputs. Both are compared every cycle against queue-based models.
// The SKID=1 instance is also checked against a table of hand-derived vectors.
module tb_pipe_stage_buf;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Clock/reset block.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic [1:0]  occupancy1;
  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [1:0]  occupancy0;

  pipe_stage_buf #(.DATA_W(32), .SKID(1), .NOP_VALUE(NOP)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occupancy1)
  );

  pipe_stage_buf #(.DATA_W(32), .SKID(0), .NOP_VALUE(NOP)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  // Scoreboard: expected contents of each stage, head first.
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q0[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver task.
  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] d, input logic ordy);
    rst_n     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  // Compare both DUTs with the models before the edge, then advance the
  // models and the clock by one edge.
  task automatic check_and_step();
    logic ir1, ir0;
    #1;
    ir1 = rst_n && (exp_q1.size() < 2);
    ir0 = rst_n && (exp_q0.size() == 0 || out_ready);
    check("m1.in_ready", 32'(in_ready1), 32'(ir1));
    check("m1.out_valid", 32'(out_valid1), 32'(exp_q1.size() > 0));
    check("m1.out_data", out_data1, (exp_q1.size() > 0) ? exp_q1[0] : NOP);
    check("m1.occupancy", 32'(occupancy1), 32'(exp_q1.size()));
    check("m0.in_ready", 32'(in_ready0), 32'(ir0));
    check("m0.out_valid", 32'(out_valid0), 32'(exp_q0.size() > 0));
    check("m0.out_data", out_data0, (exp_q0.size() > 0) ? exp_q0[0] : NOP);
    check("m0.occupancy", 32'(occupancy0), 32'(exp_q0.size()));
    if (!rst_n || flush) begin
      exp_q1.delete();
      exp_q0.delete();
    end else begin
      if (exp_q1.size() > 0 && out_ready) void'(exp_q1.pop_front());
      if (in_valid && ir1) exp_q1.push_back(in_data);
      if (exp_q0.size() > 0 && out_ready) void'(exp_q0.pop_front());
      if (in_valid && ir0) exp_q0.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  // Table of vectors: inputs, then the SKID=1 outputs expected before the edge.
  typedef struct {
    logic        r, f, iv;
    logic [31:0] d;
    logic        ordy;
    logic        ir, ov;
    logic [31:0] od;
    logic [1:0]  occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [31:0] d, input logic ordy,
                              input logic ir, input logic ov,
                              input logic [31:0] od, input logic [1:0] occ);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.occ = occ;
    return v;
  endfunction

  initial begin
    //           r  f  iv  data          or   ir ov  out_data occ
    // Reset held with in_valid=1 and DEADBEEF on the input.
    vecs.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, NOP, 0));
    vecs.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, NOP, 0));
    vecs.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, NOP, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 0, NOP, 0));
    // Streaming.
    vecs.push_back(mk(1, 0, 1, 32'h100, 1, 1, 0, NOP,     0));
    vecs.push_back(mk(1, 0, 1, 32'h104, 1, 1, 1, 32'h100, 1));
    vecs.push_back(mk(1, 0, 1, 32'h108, 1, 1, 1, 32'h104, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 32'h108, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1, 1, 0, NOP,     0));
    // Stall: out_ready drops the cycle A appears.
    vecs.push_back(mk(1, 0, 1, 32'hA, 1, 1, 0, NOP,   0));
    vecs.push_back(mk(1, 0, 1, 32'hB, 0, 1, 1, 32'hA, 1));
    vecs.push_back(mk(1, 0, 1, 32'hC, 0, 0, 1, 32'hA, 2));
    vecs.push_back(mk(1, 0, 1, 32'hC, 0, 0, 1, 32'hA, 2));
    vecs.push_back(mk(1, 0, 1, 32'hC, 1, 0, 1, 32'hA, 2));
    vecs.push_back(mk(1, 0, 1, 32'hC, 1, 1, 1, 32'hB, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0, 1, 1, 1, 32'hC, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 0, NOP,   0));
    // Flush at occupancy 2 with F00 offered.
    vecs.push_back(mk(1, 0, 1, 32'hA,   0, 1, 0, NOP,   0));
    vecs.push_back(mk(1, 0, 1, 32'hB,   0, 1, 1, 32'hA, 1));
    vecs.push_back(mk(1, 1, 1, 32'hF00, 0, 0, 1, 32'hA, 2));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1, 1, 0, NOP,   0));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1, 1, 0, NOP,   0));
    // Flush that drops an accepted same-cycle input.
    vecs.push_back(mk(1, 0, 1, 32'hD, 0, 1, 0, NOP,   0));
    vecs.push_back(mk(1, 1, 1, 32'hE, 0, 1, 1, 32'hD, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0, 1, 1, 0, NOP,   0));
    // Reset in the middle of a stall, then one send.
    vecs.push_back(mk(1, 0, 1, 32'hA1,  0, 1, 0, NOP,    0));
    vecs.push_back(mk(1, 0, 1, 32'hB1,  0, 1, 1, 32'hA1, 1));
    vecs.push_back(mk(0, 0, 1, 32'hC1,  0, 0, 1, 32'hA1, 2));
    vecs.push_back(mk(1, 0, 1, 32'h200, 1, 1, 0, NOP,    0));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1, 1, 1, 32'h200, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1, 1, 0, NOP,    0));

    // One reset edge before the table so that both DUTs start from a known state.
    drive(0, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d.in_ready", i), 32'(in_ready1), 32'(vecs[i].ir));
      check($sformatf("vec%0d.out_valid", i), 32'(out_valid1), 32'(vecs[i].ov));
      check($sformatf("vec%0d.out_data", i), out_data1, vecs[i].od);
      check($sformatf("vec%0d.occupancy", i), 32'(occupancy1), 32'(vecs[i].occ));
      check_and_step();
    end

    // SKID=0: in_ready follows out_ready in the same cycle while the stage holds data.
    drive(1, 0, 1, 32'h31, 1);
    check_and_step();
    drive(1, 0, 1, 32'h32, 0);
    #1;
    check("s0.ready_falls", 32'(in_ready0), 32'(0));
    check("s0.occ_max", 32'(occupancy0), 32'(1));
    check_and_step();
    drive(1, 0, 1, 32'h32, 1);
    #1;
    check("s0.ready_rises", 32'(in_ready0), 32'(1));
    check_and_step();
    drive(1, 0, 0, 32'h0, 1);
    check_and_step();
    check_and_step();

    // Randomized traffic compared against the models.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom(),
            ($urandom_range(0, 2) != 0));
      check_and_step();
    end

    // Final report.
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
